// File: rtl/lsu_pkg.sv
// Shared size encodings and FSM state type for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] LSU_BYTE = 2'b00;
    localparam logic [1:0] LSU_HALF = 2'b01;
    localparam logic [1:0] LSU_WORD = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_READ,
        LSU_WRITE,
        LSU_RESP
    } lsu_state_e;

    // Encoding 2'b11 is handled as a word access.
    function automatic logic lsu_is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: load extraction with sign/zero extension and
// sub-word store merge into a full memory word.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      size_i,
    input  logic [1:0]      offset_i,
    input  logic            unsigned_i,
    input  logic [XLEN-1:0] mem_word_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic [XLEN-1:0] load_data_o,
    output logic [XLEN-1:0] store_word_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (offset_i)
            2'd0:    byte_sel = mem_word_i[7:0];
            2'd1:    byte_sel = mem_word_i[15:8];
            2'd2:    byte_sel = mem_word_i[23:16];
            default: byte_sel = mem_word_i[31:24];
        endcase
        half_sel = offset_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];
    end

    always_comb begin
        load_data_o  = mem_word_i;
        store_word_o = store_data_i;
        if (size_i == LSU_BYTE) begin
            load_data_o  = {{(XLEN-8){byte_sel[7] & ~unsigned_i}}, byte_sel};
            store_word_o = mem_word_i;
            unique case (offset_i)
                2'd0:    store_word_o[7:0]   = store_data_i[7:0];
                2'd1:    store_word_o[15:8]  = store_data_i[7:0];
                2'd2:    store_word_o[23:16] = store_data_i[7:0];
                default: store_word_o[31:24] = store_data_i[7:0];
            endcase
        end else if (size_i == LSU_HALF) begin
            load_data_o  = {{(XLEN-16){half_sel[15] & ~unsigned_i}}, half_sel};
            store_word_o = mem_word_i;
            if (offset_i[1]) begin
                store_word_o[31:16] = store_data_i[15:0];
            end else begin
                store_word_o[15:0] = store_data_i[15:0];
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: request latch, FSM and captured-word register.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_error,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_write_data,
    output logic            mem_write_enable,
    input  logic [XLEN-1:0] mem_read_data
);

    lsu_state_e      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [1:0]      size_q, size_d;
    logic            write_q, write_d;
    logic            unsigned_q, unsigned_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] word_q, word_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            error_q, error_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;

    logic [XLEN-1:0] req_addr_aligned;
    logic            req_out_of_range;
    logic            req_error;
    logic [XLEN-1:0] lane_word;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] store_word;

    always_comb begin
        req_addr_aligned = req_addr;
        if (req_size == LSU_HALF) begin
            req_addr_aligned[0] = 1'b0;
        end else if (lsu_is_word(req_size)) begin
            req_addr_aligned[1:0] = 2'b00;
        end
        req_out_of_range = {2'b00, req_addr[XLEN-1:2]} >= XLEN'(DEPTH);
`ifdef LSU_MISALIGN_TRAP_EN
        req_error = req_out_of_range || (req_addr_aligned[1:0] != req_addr[1:0]);
`else
        req_error = req_out_of_range;
`endif
    end

    // During READ the merge/extract must see the word arriving this cycle.
    assign lane_word = (state_q == LSU_READ) ? mem_read_data : word_q;

    lsu_lane_align #(
        .XLEN(XLEN)
    ) u_lane_align (
        .size_i      (size_q),
        .offset_i    (addr_q[1:0]),
        .unsigned_i  (unsigned_q),
        .mem_word_i  (lane_word),
        .store_data_i(wdata_q),
        .load_data_o (load_data),
        .store_word_o(store_word)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        write_d    = write_q;
        unsigned_d = unsigned_q;
        wdata_d    = wdata_q;
        word_d     = word_q;
        rdata_d    = rdata_q;
        error_d    = error_q;
        we_d       = 1'b0;
        wr_data_d  = wr_data_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;

        unique case (state_q)
            LSU_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d     = req_addr_aligned;
                    size_d     = req_size;
                    write_d    = req_write;
                    unsigned_d = req_unsigned;
                    wdata_d    = req_wdata;
                    rdata_d    = '0;
                    error_d    = req_error;
                    if (req_error) begin
                        state_d = LSU_RESP;
                    end else if (req_write && lsu_is_word(req_size)) begin
                        state_d   = LSU_WRITE;
                        we_d      = 1'b1;
                        wr_data_d = req_wdata;
                    end else begin
                        state_d = LSU_READ;
                    end
                end
            end
            LSU_READ: begin
                word_d = mem_read_data;
                if (write_q) begin
                    state_d   = LSU_WRITE;
                    we_d      = 1'b1;
                    wr_data_d = store_word;
                end else begin
                    state_d = LSU_RESP;
                    rdata_d = load_data;
                end
            end
            LSU_WRITE: begin
                state_d = LSU_RESP;
            end
            LSU_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = LSU_IDLE;
                end
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= LSU_IDLE;
            addr_q     <= '0;
            size_q     <= LSU_WORD;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            word_q     <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
            we_q       <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            write_q    <= write_d;
            unsigned_q <= unsigned_d;
            wdata_q    <= wdata_d;
            word_q     <= word_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
            we_q       <= we_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign mem_address      = {2'b00, addr_q[XLEN-1:2]};
    assign mem_write_data   = wr_data_q;
    assign mem_write_enable = we_q;
    assign resp_rdata       = rdata_q;
    assign resp_error       = error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-word behavioural data memory.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:63];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;
    int          we_count = 0;
    logic [31:0] last_we_addr = '0;

    int errors = 0;
    int checks = 0;
    bit trap_en;

    always #5 clock = ~clock;

    load_store_unit #(
        .XLEN (32),
        .DEPTH(64)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_error      (resp_error),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_write_enable(mem_write_enable),
        .mem_read_data   (mem_read_data)
    );

    assign mem_read_data = (mem_address < 32'd64) ? mem[mem_address[5:0]] : 32'h0;

    always @(posedge clock) begin
        if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end else if (mem_write_enable) begin
            if (mem_address < 32'd64) mem[mem_address[5:0]] <= mem_write_data;
            we_count     <= we_count + 1;
            last_we_addr <= mem_address;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clock);
        pre_idx = 6'(idx);
        pre_val = val;
        pre_en  = 1'b1;
        @(posedge clock);
        #1 pre_en = 1'b0;
    endtask

    task automatic send_req(input string tag, input logic w, input logic [1:0] sz,
                            input logic u, input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        check_val({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    // Returns cycles from the accept cycle to the first cycle with resp_valid.
    task automatic wait_resp(input string tag, output int lat);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clock);
            #1 lat++;
        end
        if (!resp_valid) check_val({tag, "_timeout"}, 32'(resp_valid), 32'd1);
    endtask

    task automatic handshake();
        @(negedge clock);
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
    endtask

    task automatic do_access(input string tag, input logic w, input logic [1:0] sz,
                             input logic u, input logic [31:0] a, input logic [31:0] d,
                             input int exp_lat, input logic [31:0] exp_rdata,
                             input logic exp_err);
        int lat;
        send_req(tag, w, sz, u, a, d);
        wait_resp(tag, lat);
        check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_rdata"}, resp_rdata, exp_rdata);
        check_val({tag, "_error"}, 32'(resp_error), 32'(exp_err));
        handshake();
    endtask

    initial begin
        int wc;
        int lat;
`ifdef LSU_MISALIGN_TRAP_EN
        trap_en = 1'b1;
`else
        trap_en = 1'b0;
`endif
        #12;
        check_val("rst_req_ready", 32'(req_ready), 32'd1);
        check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst_resp_error", 32'(resp_error), 32'd0);
        check_val("rst_resp_rdata", resp_rdata, 32'h0);
        check_val("rst_mem_address", mem_address, 32'h0);
        check_val("rst_mem_wdata", mem_write_data, 32'h0);
        check_val("rst_mem_we", 32'(mem_write_enable), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        poke(5, 32'h0000F080);
        poke(63, 32'h12345678);

        // Word store then load back.
        wc = we_count;
        do_access("st_word", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0);
        check_val("st_word_we_pulses", 32'(we_count - wc), 32'd1);
        check_val("st_word_we_addr", last_we_addr, 32'd4);
        check_val("st_word_mem", mem[4], 32'hDEADBEEF);
        do_access("ld_word", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0);

        // Sub-word read-modify-write stores.
        poke(4, 32'h11223344);
        wc = we_count;
        do_access("st_byte", 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AB, 3, 32'h0, 1'b0);
        check_val("st_byte_mem", mem[4], 32'h11AB3344);
        check_val("st_byte_we_pulses", 32'(we_count - wc), 32'd1);
        do_access("st_half", 1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF5566, 3, 32'h0, 1'b0);
        check_val("st_half_mem", mem[4], 32'h55663344);

        // Extension.
        do_access("ld_sb0", 1'b0, 2'b00, 1'b0, 32'h14, 32'h0, 2, 32'hFFFFFF80, 1'b0);
        do_access("ld_uh0", 1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 2, 32'h0000F080, 1'b0);
        do_access("ld_sh0", 1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 2, 32'hFFFFF080, 1'b0);
        do_access("ld_ub1", 1'b0, 2'b00, 1'b1, 32'h15, 32'h0, 2, 32'h000000F0, 1'b0);
        do_access("ld_sb1", 1'b0, 2'b00, 1'b0, 32'h15, 32'h0, 2, 32'hFFFFFFF0, 1'b0);
        do_access("ld_size3", 1'b0, 2'b11, 1'b0, 32'h14, 32'h0, 2, 32'h0000F080, 1'b0);

        // Range boundary.
        do_access("ld_last", 1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, 2, 32'h12345678, 1'b0);
        wc = we_count;
        do_access("ld_oor", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1, 32'h0, 1'b1);
        do_access("st_oor", 1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFEF00D, 1, 32'h0, 1'b1);
        check_val("oor_no_write", 32'(we_count - wc), 32'd0);

        // Misaligned.
        if (trap_en) begin
            do_access("mis_word", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1, 32'h0, 1'b1);
            do_access("mis_half", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 1, 32'h0, 1'b1);
        end else begin
            do_access("mis_word", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 2, 32'h55663344, 1'b0);
            do_access("mis_half", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 2, 32'h00005566, 1'b0);
        end

        // Response stall.
        send_req("stall", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        wait_resp("stall", lat);
        repeat (5) @(posedge clock);
        #1;
        check_val("stall_valid", 32'(resp_valid), 32'd1);
        check_val("stall_rdata", resp_rdata, 32'h0000F080);
        check_val("stall_req_ready", 32'(req_ready), 32'd0);
        handshake();

        // Reset while a sub-word store sits in READ.
        wc = we_count;
        send_req("rst_mid", 1'b1, 2'b00, 1'b0, 32'h14, 32'h000000CD);
        reset = 1'b1;
        #1;
        check_val("rst_mid_we", 32'(mem_write_enable), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_val("rst_mid_no_write", 32'(we_count - wc), 32'd0);
        check_val("rst_mid_mem", mem[5], 32'h0000F080);
        check_val("rst_mid_req_ready", 32'(req_ready), 32'd1);
        check_val("rst_mid_resp_valid", 32'(resp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the RV32I core's execute stage and `data_memory`. It accepts one byte/halfword/word access per request over a valid/ready handshake and converts the byte address to the memory's word index. Sub-word stores are performed as read-modify-write, and load data is sign- or zero-extended. Results return on a valid/ready response channel.

## Interface
- `XLEN`, 32, data and address width
- `DEPTH`, 64, number of words in the attached `data_memory`; word indices >= DEPTH are out of range
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `req_valid` in 1: request present
- `req_ready` out 1: unit can accept a request
- `req_write` in 1: 1 = store, 0 = load
- `req_size` in 2: 00 = byte, 01 = halfword, 10 = word, 11 = treated as word
- `req_unsigned` in 1: loads only; 1 = zero-extend
- `req_addr` in XLEN: byte address
- `req_wdata` in XLEN: store data, right-aligned
- `resp_valid` out 1: response present
- `resp_ready` in 1: consumer accepts the response
- `resp_rdata` out XLEN: extended load data; 0 for stores and errors
- `resp_error` out 1: access was rejected
- `mem_address` out XLEN: word index, `{2'b00, addr[XLEN-1:2]}`
- `mem_write_data` out XLEN: full word to write
- `mem_write_enable` out 1: write strobe
- `mem_read_data` in XLEN: combinational read data from the memory

## Operation
- **States:** IDLE, READ, WRITE, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid` the unit latches addr, size, write, unsigned and wdata.
  - Next state:
    - error → RESP
    - load → READ
    - word store → WRITE
    - sub-word store → READ
- **READ**
  - `mem_address` carries the latched word index.
  - `mem_read_data` is captured into the word register at the clock edge.
  - Next state: load → RESP; sub-word store → WRITE.
- **WRITE**
  - `mem_write_enable` = 1 for exactly this cycle.
  - `mem_write_data` is either `req_wdata` (word store) or the captured word with the target lane replaced.
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - Next state → RESP.
- **RESP**
  - `resp_valid` = 1; `resp_rdata` and `resp_error` are held stable until `resp_ready`.
  - On `resp_ready` → IDLE.
- **Load extraction**
  - Byte: lane addr[1:0], bits [7:0] of that lane.
  - Halfword: lane addr[1].
  - Sign-extend from bit 7 or bit 15 unless `req_unsigned`.
  - Word loads pass through unchanged.
- **Out of range** (word index >= DEPTH):
  - `resp_error` = 1 and `resp_rdata` = 0.
  - No READ and no WRITE is issued.
- `req_ready` = 0 in every state except IDLE; requests are never queued.

## Timing
- **Reset values:**
  - state IDLE, `req_ready` 1, `resp_valid` 0, `resp_error` 0
  - `resp_rdata` 0, `mem_address` 0, `mem_write_data` 0, `mem_write_enable` 0
- **Latency**, measured from the accept edge N to `resp_valid` high:
  - Load: N+2.
  - Word store: N+2.
  - Sub-word store: N+3.
  - Error: N+1.
- **Back-to-back:** a new request can be accepted at the earliest one cycle after the response handshake; no IDLE bypass.
- **`mem_write_enable`:** registered, driven by state decode only. It is never asserted in IDLE, READ or RESP.
- **Reset mid-operation:** asserting `reset` in any state forces IDLE immediately.
  - `mem_write_enable` drops asynchronously, so a pending WRITE is suppressed.
  - The in-flight response is discarded.
- **Response stalled:** if `resp_ready` stays 0, the unit remains in RESP indefinitely with outputs held.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- **Defined:**
  - A halfword with addr[0] = 1, or a word with addr[1:0] != 0, is an error.
  - The unit goes straight to RESP with `resp_error` = 1 and `resp_rdata` = 0; there is no memory access.
- **Undefined:**
  - Misaligned addresses are force-aligned (halfword clears addr[0]; word clears addr[1:0]).
  - The access proceeds normally with `resp_error` = 0.

## Structure
- **Package `lsu_pkg`:**
  - size encodings (`LSU_BYTE`, `LSU_HALF`, `LSU_WORD`)
  - state enum (`LSU_IDLE`, `LSU_READ`, `LSU_WRITE`, `LSU_RESP`)
- **Sub-module `lsu_lane_align`:**
  - Combinational.
  - Inputs: size, addr[1:0], unsigned, memory word, store data.
  - Outputs: extended load data and merged store word.
- **Top level:** the FSM, request latches and captured-word register.

## Test plan
- **Word store then load:**
  - Store word 0xDEADBEEF to addr 0x10 → `mem_write_enable` pulses one cycle with `mem_address` = 4.
  - Load word from 0x10 → `resp_rdata` = 0xDEADBEEF at N+2.
- **Byte store read-modify-write:**
  - Word 4 = 0x11223344; store byte 0xAB at addr 0x12 → memory word = 0x11AB3344.
  - `resp_valid` at N+3.
- **Sign/zero extension:**
  - Word holds 0x0000F080.
  - Signed byte load at offset 0 → 0xFFFFFF80.
  - Unsigned halfword load at offset 0 → 0x0000F080.
- **Out of range:** load from addr 0x100 (index 64) → `resp_error` = 1, `resp_rdata` = 0, no write.
- **Misaligned access:** word load at addr 0x13.
  - With `LSU_MISALIGN_TRAP_EN`: `resp_error` = 1 at N+1.
  - Without: returns word 4 with `resp_error` = 0.
- **Response stall and reset:**
  - `resp_ready` held 0 for 5 cycles → response held stable.
  - Sub-word store with reset asserted during READ → returns to IDLE, memory unchanged, `req_ready` = 1.
